uart_tx_fsm: RTL and testbench

//   Frame sequencer for the UART transmitter. It accepts a byte request and

---
 rtl/uart_tx_fsm.sv | 105 ++++++++++
 tb/tb_uart_tx_fsm.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsm.sv
// UART Tx frame sequencer: start, LSB-first data, optional parity, stop; one bit per CLK, Moore outputs.
// Requests are taken only in IDLE or STOP (ser_load same cycle); no queueing, the requester holds Data_Valid until accepted.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  output logic       ser_load,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_IDLE   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic             par_en_q, par_en_nxt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      par_en_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      par_en_q <= par_en_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    par_en_nxt  = par_en_q;
    ser_load    = 1'b0;
    ser_en      = 1'b0;
    mux_sel     = SEL_IDLE;
    busy        = 1'b0;

    case (state)
      IDLE: begin
        if (Data_Valid) begin
          // ser_load is the only Mealy output; gate it so it drops with reset and no edge
          ser_load   = RST;
          par_en_nxt = PAR_EN;
          state_nxt  = START;
        end
      end
      START: begin
        mux_sel     = SEL_START;
        busy        = 1'b1;
        bit_cnt_nxt = '0;
        state_nxt   = DATA;
      end
      DATA: begin
        mux_sel = SEL_DATA;
        ser_en  = 1'b1;
        busy    = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_nxt = '0;
          state_nxt   = par_en_q ? PARITY : STOP;
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      PARITY: begin
        mux_sel   = SEL_PARITY;
        busy      = 1'b1;
        state_nxt = STOP;
      end
      STOP: begin
        busy = 1'b1;
        if (Data_Valid) begin
          ser_load   = RST;
          par_en_nxt = PAR_EN;
          state_nxt  = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: directed per-cycle stimulus pushes hand-derived expected outputs; a negedge monitor pops and compares.
module tb_uart_tx_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       ser_load;
  logic       ser_en;
  logic [1:0] mux_sel;
  logic       busy;

  uart_tx_fsm #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .ser_load   (ser_load),
    .ser_en     (ser_en),
    .mux_sel    (mux_sel),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  tst;
    logic [15:0] id;
    logic        ld;
    logic        en;
    logic [1:0]  sel;
    logic        bsy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   step_id  = 0;
  int   tst_id   = 0;

  // One cycle: drive inputs just after the edge and queue what that cycle must show.
  task automatic step(input logic rst, input logic dv, input logic pe,
                      input logic ld, input logic en, input logic [1:0] sel, input logic bsy);
    exp_t e;
    @(posedge CLK);
    #1;
    RST        = rst;
    Data_Valid = dv;
    PAR_EN     = pe;
    e.tst = tst_id[7:0];
    e.id  = step_id[15:0];
    e.ld  = ld;
    e.en  = en;
    e.sel = sel;
    e.bsy = bsy;
    exp_q.push_back(e);
    step_id++;
  endtask

  // START, 8 DATA cycles and optional PARITY of one frame.
  task automatic body(input logic par, input logic tog, input int ign,
                      input logic hold, input logic rst_in_par);
    step(1'b1, hold, par, 1'b0, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 8; i++)
      step(1'b1, hold | (i == ign), (tog && (i % 2 == 0)) ? ~par : par,
           1'b0, 1'b1, 2'b10, 1'b1);
    if (par) begin
      if (rst_in_par) step(1'b0, 1'b0, par, 1'b0, 1'b0, 2'b01, 1'b0);
      else            step(1'b1, hold, par, 1'b0, 1'b0, 2'b11, 1'b1);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({ser_load, ser_en, mux_sel, busy} !== {e.ld, e.en, e.sel, e.bsy}) begin
        n_fails++;
        $display("FAIL t%0d step %0d: ld/en/sel/busy actual %b/%b/%b/%b required %b/%b/%b/%b",
                 e.tst, e.id, ser_load, ser_en, mux_sel, busy, e.ld, e.en, e.sel, e.bsy);
      end
    end else if (RST === 1'b1) begin
      n_checks++;
      if ({ser_load, ser_en, mux_sel, busy} !== 5'b0_0_01_0) begin
        n_fails++;
        $display("FAIL idle_activity: ld/en/sel/busy actual %b/%b/%b/%b required 0/0/01/0",
                 ser_load, ser_en, mux_sel, busy);
      end
    end
  end

  initial begin
    RST        = 1'b0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;

    // Reset holds everything idle, even with a request pending
    tst_id = 1;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);

    // Single frame, no parity
    tst_id = 2;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    body(1'b0, 1'b0, -1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);

    // Parity frame with PAR_EN toggling during DATA
    tst_id = 3;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    body(1'b1, 1'b1, -1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);

    // Back-to-back frames: second load lands in STOP, busy never drops
    tst_id = 4;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    body(1'b0, 1'b0, -1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
    body(1'b0, 1'b0, -1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);

    // Request during DATA bit 3 is ignored; PAR_EN wiggles to 1 meanwhile
    tst_id = 5;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    body(1'b0, 1'b1, 3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);

    // Reset in PARITY aborts at once; next frame after release is complete
    tst_id = 6;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    body(1'b1, 1'b0, -1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    body(1'b0, 1'b0, -1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);

    repeat (3) @(negedge CLK);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
